// File: rtl/register_select_encoder_if.sv
// Load/drain bus of the register-select encoder: mask load request, index stream
// with valid/ready, and per-mask status (busy, done, popcount, one-hot).
`timescale 1ns/1ps
interface register_select_encoder_if #(
  parameter int NBITS = 32,
  parameter int IDX_W = 5
);
  logic [NBITS-1:0] SelectMask_i;
  logic             Load_i;
  logic             Ready_i;
  logic             Busy_o;
  logic             Valid_o;
  logic [IDX_W-1:0] Index_o;
  logic             Done_o;
  logic             OneHot_o;
  logic [IDX_W:0]   Count_o;

  // The master loads masks and consumes indices; the slave is the encoder.
  modport master (
    output SelectMask_i, Load_i, Ready_i,
    input  Busy_o, Valid_o, Index_o, Done_o, OneHot_o, Count_o
  );

  modport slave (
    input  SelectMask_i, Load_i, Ready_i,
    output Busy_o, Valid_o, Index_o, Done_o, OneHot_o, Count_o
  );
endinterface

// File: rtl/register_select_encoder.sv
// Register-select encoder: captures a register mask and streams the index of each
// set bit, lowest first, one per valid/ready handshake, then pulses Done_o.
`timescale 1ns/1ps
module register_select_encoder #(
  parameter int NBITS = 32,
  parameter int IDX_W = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  register_select_encoder_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [NBITS-1:0] mask_q, mask_d;
  logic [IDX_W:0]   count_q, count_d;
  logic             one_hot_q, one_hot_d;

  logic [IDX_W-1:0] low_idx;
  logic [IDX_W:0]   load_pop;

  // Priority encode of the pending mask: scanning high to low leaves the lowest set bit.
  always_comb begin
    low_idx = '0;
    for (int i = NBITS - 1; i >= 0; i--) begin
      if (mask_q[i]) low_idx = IDX_W'(i);
    end
  end

  always_comb begin
    load_pop = '0;
    for (int i = 0; i < NBITS; i++) begin
      load_pop = load_pop + (IDX_W + 1)'(bus.SelectMask_i[i]);
    end
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    state_d   = state_q;
    mask_d    = mask_q;
    count_d   = count_q;
    one_hot_d = one_hot_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.Load_i) begin
          mask_d    = bus.SelectMask_i;
          count_d   = load_pop;
          one_hot_d = (load_pop == (IDX_W + 1)'(1));
          state_d   = (|bus.SelectMask_i) ? ST_DRAIN : ST_DONE;
        end
      end
      ST_DRAIN: begin
        if (bus.Ready_i) begin
          // m & (m - 1) clears exactly the lowest set bit, i.e. the one just accepted.
          mask_d  = mask_q & (mask_q - NBITS'(1));
          state_d = (mask_d == '0) ? ST_DONE : ST_DRAIN;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the mask register is a plain flop vector, not a memory, so it is reset with the rest.
      state_q   <= ST_IDLE;
      mask_q    <= '0;
      count_q   <= '0;
      one_hot_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      count_q   <= count_d;
      one_hot_q <= one_hot_d;
    end
  end

  // All outputs decode registered state only; nothing combinational from the inputs.
  assign bus.Busy_o   = (state_q == ST_DRAIN) || (state_q == ST_DONE);
  assign bus.Valid_o  = (state_q == ST_DRAIN);
  assign bus.Index_o  = (state_q == ST_DRAIN) ? low_idx : '0;
  assign bus.Done_o   = (state_q == ST_DONE);
  assign bus.Count_o  = count_q;
  assign bus.OneHot_o = one_hot_q;

endmodule

// File: tb/tb_register_select_encoder.sv
// Self-checking bench for register_select_encoder: directed masks, stalls, reset
// abort and randomized masks/backpressure against a queue-based index model.
`timescale 1ns/1ps
module tb_register_select_encoder;
  localparam int NBITS = 32;
  localparam int IDX_W = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  register_select_encoder_if #(.NBITS(NBITS), .IDX_W(IDX_W)) bus ();

  register_select_encoder #(.NBITS(NBITS), .IDX_W(IDX_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Observation vector: {busy, valid, index[4:0], done, count[5:0], one_hot}
  function automatic logic [14:0] observed();
    return {bus.Busy_o, bus.Valid_o, bus.Index_o, bus.Done_o, bus.Count_o, bus.OneHot_o};
  endfunction

  // Loads a mask, drains it and checks every cycle against a model built from the
  // list of set-bit positions. Ready is held low for 'stall' cycles (with Load_i
  // pulsed meanwhile), then held high or randomized. Returns the cycle of Done_o.
  task automatic run_mask(input logic [31:0] mask, input bit rnd, input int stall,
                          input string name, output int done_cycle);
    int q[$];
    int cnt;
    int cyc;
    bit ready;
    logic [14:0] exp;
    for (int i = 0; i < NBITS; i++) if (mask[i]) q.push_back(i);
    cnt = q.size();
    done_cycle = -1;
    bus.SelectMask_i = mask;
    bus.Load_i       = 1'b1;
    bus.Ready_i      = 1'b0;
    @(negedge clk);
    bus.Load_i = 1'b0;
    cyc = 1;
    forever begin
      if (q.size() != 0)
        exp = {1'b1, 1'b1, 5'(q[0]), 1'b0, 6'(cnt), cnt == 1};
      else
        exp = {1'b1, 1'b0, 5'd0, 1'b1, 6'(cnt), cnt == 1};
      total++;
      if (observed() !== exp) begin
        bad++;
        $display("FAIL %s cycle %0d: got {busy,valid,idx,done,cnt,oh}=%h want %h",
                 name, cyc, observed(), exp);
      end
      if (q.size() == 0) begin
        done_cycle = cyc;
        break;
      end
      ready            = (cyc <= stall) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      bus.Ready_i      = ready;
      bus.Load_i       = (cyc <= stall) ? 1'b1 : (rnd ? 1'($urandom_range(0, 1)) : 1'b0);
      bus.SelectMask_i = $urandom();
      @(negedge clk);
      if (ready) void'(q.pop_front());
      cyc++;
      if (cyc > 400) begin
        total++;
        bad++;
        $display("FAIL %s timeout: no Done_o within 400 cycles", name);
        break;
      end
    end
    bus.Load_i  = 1'b0;
    bus.Ready_i = 1'b0;
    @(negedge clk);
    exp = {1'b0, 1'b0, 5'd0, 1'b0, 6'(cnt), cnt == 1};
    total++;
    if (observed() !== exp) begin
      bad++;
      $display("FAIL %s idle after done: got %h want %h", name, observed(), exp);
    end
  endtask

  task automatic test_reset();
    reset            = 1'b0;
    bus.SelectMask_i = 32'hFFFF_FFFF;
    bus.Load_i       = 1'b1;
    bus.Ready_i      = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (observed() !== 15'd0) begin
      bad++;
      $display("FAIL reset_state: got %h want %h", observed(), 15'd0);
    end
    bus.Load_i  = 1'b0;
    bus.Ready_i = 1'b0;
    reset       = 1'b1;
    @(negedge clk);
    total++;
    if (observed() !== 15'd0) begin
      bad++;
      $display("FAIL reset_release_idle: got %h want %h", observed(), 15'd0);
    end
  endtask

  task automatic test_directed();
    int dc;
    run_mask(32'h0000_0001, 1'b0, 0, "single_bit0", dc);
    run_mask(32'h8000_0010, 1'b0, 0, "bits_4_31", dc);
    run_mask(32'h0000_0C00, 1'b0, 3, "stall_10_11", dc);
    run_mask(32'h0000_0000, 1'b0, 0, "zero_mask", dc);
    total++;
    if (dc !== 1) begin
      bad++;
      $display("FAIL zero_mask_done_cycle: got %0d want 1", dc);
    end
  endtask

  task automatic test_full();
    int dc;
    run_mask(32'hFFFF_FFFF, 1'b0, 0, "full_mask", dc);
    total++;
    if (dc !== 33) begin
      bad++;
      $display("FAIL full_mask_done_cycle: got %0d want 33", dc);
    end
  endtask

  task automatic test_reset_abort();
    int dc;
    bus.SelectMask_i = 32'h00F0_0000;
    bus.Load_i       = 1'b1;
    bus.Ready_i      = 1'b0;
    @(negedge clk);
    bus.Load_i = 1'b0;
    total++;
    if (observed() !== {1'b1, 1'b1, 5'd20, 1'b0, 6'd4, 1'b0}) begin
      bad++;
      $display("FAIL abort_first_index: got %h want %h", observed(),
               {1'b1, 1'b1, 5'd20, 1'b0, 6'd4, 1'b0});
    end
    bus.Ready_i = 1'b1;
    @(negedge clk);
    total++;
    if (observed() !== {1'b1, 1'b1, 5'd21, 1'b0, 6'd4, 1'b0}) begin
      bad++;
      $display("FAIL abort_second_index: got %h want %h", observed(),
               {1'b1, 1'b1, 5'd21, 1'b0, 6'd4, 1'b0});
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if (observed() !== 15'd0) begin
      bad++;
      $display("FAIL abort_async_clear: got %h want %h", observed(), 15'd0);
    end
    @(negedge clk);
    total++;
    if (observed() !== 15'd0) begin
      bad++;
      $display("FAIL abort_no_done: got %h want %h", observed(), 15'd0);
    end
    bus.Ready_i = 1'b0;
    reset       = 1'b1;
    @(negedge clk);
    run_mask(32'h0000_0002, 1'b0, 0, "after_abort", dc);
  endtask

  task automatic test_back_to_back();
    int dc;
    run_mask(32'h0000_0005, 1'b0, 0, "b2b_a", dc);
    run_mask(32'h4000_0000, 1'b0, 0, "b2b_b", dc);
  endtask

  task automatic test_random();
    int dc;
    logic [31:0] m;
    for (int n = 0; n < 24; n++) begin
      case (n % 4)
        0: m = $urandom() & $urandom() & $urandom();
        1: m = $urandom();
        2: m = $urandom() | $urandom();
        default: m = 32'h1 << $urandom_range(0, 31);
      endcase
      run_mask(m, 1'b1, int'($urandom_range(0, 2)), $sformatf("random_%0d", n), dc);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_full();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
